// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the oscillator, waits for it to settle,
// then counts synchronised rising edges of osc_in over a gate_len-cycle window.
module ro_freq_counter #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              osc_in,
    output logic              ro_ena,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   osc_rise;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       edge_cnt_nxt;
    logic                   sat;
    logic                   sat_nxt;
    logic [SET_W-1:0]       settle_cnt;
    logic [GATE_W-1:0]      gate_cnt;
    logic [GATE_W-1:0]      gate_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign osc_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Saturating increment; sat marks an edge lost while the counter was full.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        sat_nxt      = sat;
        if (state == ST_GATE && osc_rise) begin
            if (&edge_cnt) begin
                sat_nxt = 1'b1;
            end else begin
                edge_cnt_nxt = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (settle_cnt == '0) begin
                    state_nxt = (gate_len_q == '0) ? ST_DONE : ST_GATE;
                end
            end
            ST_GATE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (gate_cnt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            gate_len_q <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        gate_len_q <= gate_len;
                        edge_cnt   <= '0;
                        sat        <= 1'b0;
                        settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end else begin
                        gate_cnt <= gate_len_q - GATE_W'(1);
                    end
                end
                ST_GATE: begin
                    edge_cnt <= edge_cnt_nxt;
                    sat      <= sat_nxt;
                    if (gate_cnt != '0) begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
                default: ;
            endcase
            // Result is latched on entry to DONE so it is valid alongside the done pulse.
            if (state_nxt == ST_DONE) begin
                count    <= edge_cnt_nxt;
                overflow <= sat_nxt;
            end
        end
    end

    assign ro_ena = (state == ST_SETTLE) || (state == ST_GATE);
    assign busy   = ro_ena;
    assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: directed table, hand-written corner
// sequences and randomized runs checked against an edge-counting reference model.
module tb_ro_freq_counter;

    localparam int CNT_W  = 8;
    localparam int GATE_W = 16;
    localparam int SETTLE = 8;
    localparam int SYNC   = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_len;
    logic              osc_in;
    logic              ro_ena;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    ro_freq_counter #(
        .CNT_W        (CNT_W),
        .GATE_W       (GATE_W),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .gate_len(gate_len),
        .osc_in  (osc_in),
        .ro_ena  (ro_ena),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gate;
        int half;
        int cnt_lo;
        int cnt_hi;
        int ovf;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int osc_half    = 0;
    int osc_hold    = 0;
    bit hist [int];
    int m_count     = 0;
    int m_ovf       = 0;
    int last_count  = 0;
    int last_ovf    = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
        end
    endtask

    function automatic bit h(input int k);
        return hist.exists(k) ? hist[k] : 1'b0;
    endfunction

    // Rising edges of osc_in as driven in cycles lo..hi.
    function automatic int rises(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) begin
            if (h(k) && !h(k - 1)) n++;
        end
        return n;
    endfunction

    // Advance one clock; osc_in for the new cycle is driven and recorded 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (osc_half > 0) begin
            osc_in = ((cyc / osc_half) % 2) == 1;
        end else if (osc_hold <= 1) begin
            osc_in   = !osc_in;
            osc_hold = $urandom_range(6, 2);
        end else begin
            osc_hold--;
        end
        hist[cyc] = osc_in;
    endtask

    // One measurement started in the current cycle; every cycle through to the
    // following IDLE cycle checks ro_ena/busy/done/count/overflow against the model.
    task automatic run(input int g, input int abort_at, input bit poke);
        int t;
        int n;
        int lim;
        bit aborted;
        bit exp_busy;
        bit exp_done;
        t        = cyc;
        gate_len = GATE_W'(g);
        start    = 1'b1;
        abort    = 1'b0;
        step();
        start    = 1'b0;
        aborted  = 1'b0;
        lim      = t + SETTLE + 1 + g;
        for (int c = t + 1; c <= lim + 1; c++) begin
            exp_busy = !aborted && (c <= lim - 1);
            exp_done = !aborted && (c == lim);
            if (exp_done) begin
                // Edge visible to the counter SYNC cycles after osc_in rises; window is the g GATE cycles.
                n       = rises(t + SETTLE + 1 - SYNC, t + SETTLE + g - SYNC);
                m_count = (n > CMAX) ? CMAX : n;
                m_ovf   = (n > CMAX) ? 1 : 0;
                last_count = int'(count);
                last_ovf   = int'(overflow);
            end
            chk("busy", int'(busy), int'(exp_busy));
            chk("ro_ena", int'(ro_ena), int'(exp_busy));
            chk("done", int'(done), int'(exp_done));
            chk("count", int'(count), m_count);
            chk("overflow", int'(overflow), m_ovf);
            gate_len = GATE_W'($urandom);
            start    = poke && !aborted && (c <= lim) && ((c - t) % 5 == 0);
            abort    = !aborted && (c == t + abort_at);
            if (abort) aborted = 1'b1;
            step();
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    vec_t tbl[4];

    initial begin
        int g;
        int ab;
        bit pk;

        tbl[0] = '{gate: 100,  half: 4, cnt_lo: 12,  cnt_hi: 13,  ovf: 0};
        tbl[1] = '{gate: 0,    half: 4, cnt_lo: 0,   cnt_hi: 0,   ovf: 0};
        tbl[2] = '{gate: 2000, half: 2, cnt_lo: 255, cnt_hi: 255, ovf: 1};
        tbl[3] = '{gate: 40,   half: 2, cnt_lo: 9,   cnt_hi: 10,  ovf: 0};

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        gate_len = '0;
        osc_in   = 1'b0;
        hist[0]  = 1'b0;
        #3;
        chk("rst_ro_ena", int'(ro_ena), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        step();
        step();
        #2 rst_n = 1'b1;
        repeat (3) step();

        foreach (tbl[i]) begin
            osc_half = tbl[i].half;
            run(tbl[i].gate, -1, 1'b0);
            chk_range("tbl_count", last_count, tbl[i].cnt_lo, tbl[i].cnt_hi);
            chk("tbl_overflow", last_ovf, tbl[i].ovf);
        end

        // Abort mid-GATE: previous result must survive, no done.
        osc_half = 4;
        run(100, 20, 1'b0);

        // start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        gate_len = GATE_W'(30);
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_ro_ena", int'(ro_ena), 0);
        step();
        chk("start_abort_busy2", int'(busy), 0);

        // Starts every 5 cycles while busy are ignored; next run begins at first IDLE start.
        run(50, -1, 1'b1);
        run(20, -1, 1'b0);

        // Async reset mid-GATE.
        gate_len = GATE_W'(100);
        start    = 1'b1;
        step();
        start    = 1'b0;
        repeat (20) step();
        chk("pre_reset_busy", int'(busy), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_ro_ena", int'(ro_ena), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_count", int'(count), 0);
        chk("async_overflow", int'(overflow), 0);
        m_count = 0;
        m_ovf   = 0;
        step();
        step();
        #2 rst_n = 1'b1;
        repeat (3) step();
        run(30, -1, 1'b0);
        chk_range("post_reset_count", last_count, 3, 4);

        // Randomized measurements against the reference model.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(3, 0) == 0) begin
                osc_half = 2;
                g = $urandom_range(1200, 600);
            end else begin
                osc_half = 0;
                g = $urandom_range(200, 0);
            end
            ab = ($urandom_range(3, 0) == 0) ? $urandom_range(SETTLE + g, 1) : -1;
            pk = ($urandom_range(3, 0) == 0);
            run(g, ab, pk);
            repeat ($urandom_range(3, 0)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
